// File: rtl/load_return_align.sv
// ----------------------------------------------------------------------------
// load_return_align
//
// Load-return stage at the MEM->WB boundary. Captures a load's opcode, byte
// offset and destination register when the load leaves MEM, takes the data
// SRAM read word one cycle later, extracts the addressed byte/halfword with
// sign or zero extension, and drives the register-file write port. The SRAM
// word is held across pipeline stalls, and loads killed by flushes are
// dropped. The stage also raises the load-use hazard stall toward ID.
//
// Ports
//   clk, rst        pipeline clock, asynchronous active-high reset
//   stall           pipeline hold; MEM/WB state must not advance
//   flush           exception flush; discards any pending load
//   req_valid       MEM stage holds a load this cycle
//   LSOp_mem[2:0]   LB/LBU/LH/LHU/LW = 000..100; 101..111 are stores
//   addr_lo[1:0]    low address bits of the MEM-stage access
//   rw_mem[4:0]     load destination register
//   Exc_mem         MEM-stage exception; blocks acceptance
//   data_rdata[31:0] SRAM read word, valid the cycle after the address
//   LSOp_ex[2:0]    EX-stage opcode (not needed by the hazard check)
//   isLoad_ex       EX stage holds a load
//   rw_ex[4:0]      EX-stage destination
//   rs_id, rt_id    ID-stage source registers
//   wb_we           register-file write enable
//   wb_rw[4:0]      register-file write address
//   wb_data[31:0]   aligned, extended load data (0 when wb_we=0)
//   busy            a load is pending or held
//   ld_stall        load-use hazard; ID/IF must hold
// ----------------------------------------------------------------------------
module load_return_align (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        req_valid,
   input  logic [2:0]  LSOp_mem,
   input  logic [1:0]  addr_lo,
   input  logic [4:0]  rw_mem,
   input  logic        Exc_mem,
   input  logic [31:0] data_rdata,
   input  logic [2:0]  LSOp_ex,
   input  logic        isLoad_ex,
   input  logic [4:0]  rw_ex,
   input  logic [4:0]  rs_id,
   input  logic [4:0]  rt_id,
   output logic        wb_we,
   output logic [4:0]  wb_rw,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic        ld_stall
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,  // no load in flight
      ST_PEND = 2'b01,  // SRAM word is on data_rdata this cycle
      ST_HELD = 2'b10   // SRAM word captured in hold_q
   } state_e;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;

   state_e      state_q, state_d;
   logic [2:0]  op_q,   op_d;
   logic [1:0]  addr_q, addr_d;
   logic [4:0]  rw_q,   rw_d;
   logic [31:0] hold_q, hold_d;

   logic        accept;
   logic        retire;
   logic [31:0] src_word;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] aligned;

   // Opcodes above LW are stores and must never enter the return path.
   assign accept = req_valid & ~stall & ~flush & ~Exc_mem & (LSOp_mem <= OP_LW);
   assign retire = (state_q != ST_IDLE) & ~stall & ~flush;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         // Flush beats both a retiring load and a new accept.
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = accept ? ST_PEND : ST_IDLE;
            ST_PEND: begin
               if (stall)       state_d = ST_HELD;
               else if (accept) state_d = ST_PEND;
               else             state_d = ST_IDLE;
            end
            ST_HELD: begin
               if (stall)       state_d = ST_HELD;
               else if (accept) state_d = ST_PEND;
               else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Captured load fields and stall hold register
   // -------------------------------------------------------------------------
   always_comb begin
      op_d   = op_q;
      addr_d = addr_q;
      rw_d   = rw_q;
      hold_d = hold_q;
      // accept already excludes stall, so the fields freeze while held.
      if (accept) begin
         op_d   = LSOp_mem;
         addr_d = addr_lo;
         rw_d   = rw_mem;
      end
      // The SRAM only drives the word for one cycle; keep it if WB cannot
      // take it yet.
      if ((state_q == ST_PEND) && stall && !flush) begin
         hold_d = data_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= 3'b000;
         addr_q <= 2'b00;
         rw_q   <= 5'd0;
         hold_q <= 32'd0;
      end else begin
         op_q   <= op_d;
         addr_q <= addr_d;
         rw_q   <= rw_d;
         hold_q <= hold_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: alignment and write-back port
   // -------------------------------------------------------------------------
   always_comb begin
      src_word = (state_q == ST_HELD) ? hold_q : data_rdata;

      unique case (addr_q)
         2'd0:    sel_byte = src_word[7:0];
         2'd1:    sel_byte = src_word[15:8];
         2'd2:    sel_byte = src_word[23:16];
         default: sel_byte = src_word[31:24];
      endcase

      // addr_q[0] is ignored for halfwords; misalignment traps upstream.
      sel_half = addr_q[1] ? src_word[31:16] : src_word[15:0];

      case (op_q)
         OP_LB:   aligned = {{24{sel_byte[7]}}, sel_byte};
         OP_LBU:  aligned = {24'd0, sel_byte};
         OP_LH:   aligned = {{16{sel_half[15]}}, sel_half};
         OP_LHU:  aligned = {16'd0, sel_half};
         default: aligned = src_word;
      endcase

      wb_we   = retire;
      wb_rw   = retire ? rw_q : 5'd0;
      wb_data = retire ? aligned : 32'd0;
      busy    = (state_q != ST_IDLE);
   end

   // Load-use hazard: purely combinational, independent of the return FSM.
   assign ld_stall = isLoad_ex & (rw_ex != 5'd0) & ((rw_ex == rs_id) | (rw_ex == rt_id));

   // The EX opcode is part of the pipeline bundle but isLoad_ex already
   // identifies loads, so it does not contribute to any logic here.
   logic unused_lsop_ex;
   assign unused_lsop_ex = ^LSOp_ex;

endmodule
